// File: rtl/spi_transfer_controller_if.sv
// Bundle of register-side and SPI-side signals for spi_transfer_controller.
// The master modport drives requests and strobes; the slave modport is the controller.
interface spi_transfer_controller_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_start;
   logic [DATA_WIDTH-1:0] i_tx_data;
   logic                  i_mstr;
   logic                  i_sample_spi_data;
   logic                  i_setup_spi_data;
   logic                  i_miso;
   logic                  o_gen_reset;
   logic                  o_sclk_en;
   logic                  o_mosi;
   logic                  o_ss_n;
   logic                  o_busy;
   logic                  o_done;
   logic [DATA_WIDTH-1:0] o_rx_data;

   modport master (
      output i_start, i_tx_data, i_mstr,
      output i_sample_spi_data, i_setup_spi_data, i_miso,
      input  o_gen_reset, o_sclk_en, o_mosi,
      input  o_ss_n, o_busy, o_done, o_rx_data
   );

   modport slave (
      input  i_start, i_tx_data, i_mstr,
      input  i_sample_spi_data, i_setup_spi_data, i_miso,
      output o_gen_reset, o_sclk_en, o_mosi,
      output o_ss_n, o_busy, o_done, o_rx_data
   );
endinterface

// File: rtl/spi_transfer_controller.sv
// Master-mode SPI word sequencer driven by clock-generator sample/setup strobes.
// Define SPI_LOOPBACK_EN to feed the rx shifter from o_mosi instead of i_miso.
module spi_transfer_controller #(
   parameter int DATA_WIDTH      = 8,
   parameter int SS_SETUP_CYCLES = 2,
   parameter int SS_HOLD_CYCLES  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   spi_transfer_controller_if.slave bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] XFER  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam int SW   = $clog2(DATA_WIDTH + 1);
   localparam int CMAX = (SS_SETUP_CYCLES > SS_HOLD_CYCLES) ?
                         SS_SETUP_CYCLES : SS_HOLD_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [SW-1:0] LAST_SMP  = SW'(DATA_WIDTH - 1);
   localparam logic [SW-1:0] FULL_SMP  = SW'(DATA_WIDTH);
   localparam logic [CW-1:0] SETUP_END = CW'(SS_SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_END  = CW'(SS_HOLD_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
   logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
   logic                  gen_reset_q, gen_reset_d;
   logic                  sclk_en_q, sclk_en_d;
   logic                  ss_n_q, ss_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rx_bit;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit = tx_shift_q[DATA_WIDTH-1];
`else
   assign rx_bit = bus.i_miso;
`endif

   always_comb begin
      state_d      = state_q;
      tx_shift_d   = tx_shift_q;
      rx_shift_d   = rx_shift_q;
      sample_cnt_d = sample_cnt_q;
      cyc_cnt_d    = cyc_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_start && bus.i_mstr) begin
               tx_shift_d   = bus.i_tx_data;
               rx_shift_d   = '0;
               sample_cnt_d = '0;
               cyc_cnt_d    = '0;
               state_d      = SETUP;
            end
         end
         SETUP: begin
            if (cyc_cnt_q == SETUP_END) begin
               cyc_cnt_d = '0;
               state_d   = XFER;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         XFER: begin
            // sample wins over a coincident setup strobe
            if (bus.i_sample_spi_data) begin
               rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], rx_bit};
               if (sample_cnt_q != FULL_SMP)
                  sample_cnt_d = sample_cnt_q + 1'b1;
               if (sample_cnt_q == LAST_SMP)
                  state_d = HOLD;
            end else if (bus.i_setup_spi_data &&
                         sample_cnt_q != '0 &&
                         sample_cnt_q < FULL_SMP) begin
               tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         HOLD: begin
            if (cyc_cnt_q == HOLD_END) begin
               cyc_cnt_d = '0;
               state_d   = DONE;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs are decoded from the next state so they register with it
   always_comb begin
      gen_reset_d = (state_d != XFER);
      sclk_en_d   = (state_d == XFER);
      ss_n_d      = !((state_d == SETUP) || (state_d == XFER) ||
                      (state_d == HOLD));
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      rx_data_d   = (state_d == DONE) ? rx_shift_q : rx_data_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         tx_shift_q   <= '0;
         rx_shift_q   <= '0;
         rx_data_q    <= '0;
         sample_cnt_q <= '0;
         cyc_cnt_q    <= '0;
         gen_reset_q  <= 1'b1;
         sclk_en_q    <= 1'b0;
         ss_n_q       <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_shift_q   <= tx_shift_d;
         rx_shift_q   <= rx_shift_d;
         rx_data_q    <= rx_data_d;
         sample_cnt_q <= sample_cnt_d;
         cyc_cnt_q    <= cyc_cnt_d;
         gen_reset_q  <= gen_reset_d;
         sclk_en_q    <= sclk_en_d;
         ss_n_q       <= ss_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.o_gen_reset = gen_reset_q;
   assign bus.o_sclk_en   = sclk_en_q;
   assign bus.o_mosi      = tx_shift_q[DATA_WIDTH-1];
   assign bus.o_ss_n      = ss_n_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_rx_data   = rx_data_q;
endmodule

// File: tb/tb_spi_transfer_controller.sv
// Directed bench for spi_transfer_controller; strobes are driven directly.
// Expected rx words follow SPI_LOOPBACK_EN when it is defined.
module tb_spi_transfer_controller;
   localparam int DW = 8;
`ifdef SPI_LOOPBACK_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   logic [7:0] mb;

   always #5 clk = ~clk;

   spi_transfer_controller_if #(.DATA_WIDTH(DW)) bus ();

   spi_transfer_controller #(
      .DATA_WIDTH(DW),
      .SS_SETUP_CYCLES(2),
      .SS_HOLD_CYCLES(2)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .bus(bus)
   );

   always @(posedge clk)
      if (bus.o_done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_rx(input logic [7:0] tx,
                                          input logic [7:0] slv);
      return LOOP ? tx : slv;
   endfunction

   task automatic pulse_setup();
      bus.i_setup_spi_data = 1'b1;
      @(negedge clk);
      bus.i_setup_spi_data = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_xfer(input logic [7:0] tx, input bit stb_setup);
      @(negedge clk);
      chk("idle_busy", bus.o_busy, 0);
      bus.i_start   = 1'b1;
      bus.i_tx_data = tx;
      @(negedge clk);
      bus.i_start   = 1'b0;
      bus.i_tx_data = 8'h00;
      chk("start_ss_low", bus.o_ss_n, 0);
      chk("start_busy", bus.o_busy, 1);
      chk("start_mosi_msb", bus.o_mosi, tx[7]);
      chk("setup_gen_rst", bus.o_gen_reset, 1);
      if (stb_setup) bus.i_sample_spi_data = 1'b1;
      @(negedge clk);
      bus.i_sample_spi_data = 1'b0;
      chk("setup_sclk_off", bus.o_sclk_en, 0);
      @(negedge clk);
      chk("xfer_sclk_on", bus.o_sclk_en, 1);
      chk("xfer_gen_rst", bus.o_gen_reset, 0);
   endtask

   task automatic run_bits(input logic [7:0] slv, input bit cpha,
                           input int rst_at, input bit restart,
                           output logic [7:0] mosi_bits);
      mosi_bits = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (cpha) pulse_setup();
         bus.i_miso = slv[7-i];
         mosi_bits[7-i] = bus.o_mosi;
         bus.i_sample_spi_data = 1'b1;
         if (i == rst_at) rst = 1'b1;
         @(negedge clk);
         bus.i_sample_spi_data = 1'b0;
         if (i == rst_at) begin
            rst = 1'b0;
            return;
         end
         if (i == 7) return;
         if (restart && i == 3) begin
            bus.i_start   = 1'b1;
            bus.i_tx_data = 8'hFF;
         end
         @(negedge clk);
         bus.i_start = 1'b0;
         if (!cpha) pulse_setup();
      end
   endtask

   task automatic finish_xfer(input logic [7:0] rx, input logic [7:0] tx);
      chk("hold_ss_low", bus.o_ss_n, 0);
      chk("hold_sclk_off", bus.o_sclk_en, 0);
      chk("hold_gen_rst", bus.o_gen_reset, 1);
      chk("hold_no_done", bus.o_done, 0);
      bus.i_setup_spi_data = 1'b1;
      @(negedge clk);
      bus.i_setup_spi_data = 1'b0;
      chk("hold_no_done2", bus.o_done, 0);
      @(negedge clk);
      chk("done_pulse", bus.o_done, 1);
      chk("done_ss_high", bus.o_ss_n, 1);
      chk("done_rx_data", bus.o_rx_data, rx);
      chk("done_mosi_lsb", bus.o_mosi, tx[0]);
   endtask

   initial begin
      rst = 1'b1;
      bus.i_start = 1'b0;
      bus.i_tx_data = 8'h00;
      bus.i_mstr = 1'b1;
      bus.i_sample_spi_data = 1'b0;
      bus.i_setup_spi_data = 1'b0;
      bus.i_miso = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gen_reset", bus.o_gen_reset, 1);
      chk("rst_sclk_en", bus.o_sclk_en, 0);
      chk("rst_mosi", bus.o_mosi, 0);
      chk("rst_ss_n", bus.o_ss_n, 1);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_rx_data", bus.o_rx_data, 0);
      rst = 1'b0;

      // master disabled: start is ignored
      @(negedge clk);
      bus.i_mstr = 1'b0;
      bus.i_start = 1'b1;
      bus.i_tx_data = 8'hAA;
      @(negedge clk);
      bus.i_start = 1'b0;
      chk("nomstr_busy", bus.o_busy, 0);
      chk("nomstr_ss", bus.o_ss_n, 1);
      @(negedge clk);
      chk("nomstr_busy2", bus.o_busy, 0);
      chk("nomstr_done_cnt", done_cnt, 0);
      bus.i_mstr = 1'b1;

      // mode 0, tx A5, stray sample strobe during SETUP
      start_xfer(8'hA5, 1'b1);
      run_bits(8'h5A, 1'b0, -1, 1'b0, mb);
      chk("t1_mosi_bits", mb, 8'hA5);
      finish_xfer(exp_rx(8'hA5, 8'h5A), 8'hA5);
      @(negedge clk);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_idle", bus.o_busy, 0);

      // cpha=1, tx 3C, slave 81; mstr drops mid-transfer
      start_xfer(8'h3C, 1'b0);
      bus.i_mstr = 1'b0;
      run_bits(8'h81, 1'b1, -1, 1'b0, mb);
      chk("t2_mosi_bits", mb, 8'h3C);
      finish_xfer(exp_rx(8'h3C, 8'h81), 8'h3C);
      bus.i_mstr = 1'b1;
      @(negedge clk);
      chk("t2_done_cnt", done_cnt, 2);

      // start pulsed mid-XFER with tx FF
      start_xfer(8'h66, 1'b0);
      run_bits(8'h99, 1'b0, -1, 1'b1, mb);
      chk("t3_mosi_bits", mb, 8'h66);
      finish_xfer(exp_rx(8'h66, 8'h99), 8'h66);
      repeat (4) @(negedge clk);
      chk("t3_not_queued", bus.o_busy, 0);
      chk("t3_done_cnt", done_cnt, 3);

      // back-to-back: start in the cycle after done
      start_xfer(8'h5A, 1'b0);
      run_bits(8'h12, 1'b0, -1, 1'b0, mb);
      finish_xfer(exp_rx(8'h5A, 8'h12), 8'h5A);
      start_xfer(8'hC3, 1'b0);
      run_bits(8'h34, 1'b0, -1, 1'b0, mb);
      chk("t6_mosi_bits", mb, 8'hC3);
      finish_xfer(exp_rx(8'hC3, 8'h34), 8'hC3);
      repeat (3) @(negedge clk);
      chk("t6_done_cnt", done_cnt, 5);
      chk("t6_rx_held", bus.o_rx_data, exp_rx(8'hC3, 8'h34));

      // reset at the 4th sample
      start_xfer(8'hF0, 1'b0);
      run_bits(8'hFF, 1'b0, 3, 1'b0, mb);
      chk("t4_ss_n", bus.o_ss_n, 1);
      chk("t4_gen_reset", bus.o_gen_reset, 1);
      chk("t4_busy", bus.o_busy, 0);
      chk("t4_sclk_en", bus.o_sclk_en, 0);
      chk("t4_rx_data", bus.o_rx_data, 0);
      chk("t4_mosi", bus.o_mosi, 0);
      repeat (4) @(negedge clk);
      chk("t4_no_done", done_cnt, 5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
